// File: rtl/thread_state_store.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | thread_state_store: per-thread WIDTH-bit context RAM with valid bits,     |
// | write-first bypass, 1/2-cycle read latency and optional post-reset sweep. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module thread_state_store #(
  parameter int               N_THREADS      = 16,
  parameter int               N_THREADS_MSB  = $clog2(N_THREADS) - 1,
  parameter int               WIDTH          = 64,
  parameter int               RD_LATENCY     = 1,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_THREADS_MSB:0] wr_thread_num,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  input  logic [N_THREADS_MSB:0] inv_thread_num,
  input  logic                   inv_en,
  input  logic [N_THREADS_MSB:0] rd_thread_num,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic                   dout_strobe,
  output logic                   ready
);

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [N_THREADS_MSB:0] LAST_SLOT = (N_THREADS_MSB + 1)'(N_THREADS - 1);

  state_t                 state_q, state_d;
  logic [N_THREADS_MSB:0] sweep_cnt_q, sweep_cnt_d;
  logic [N_THREADS-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0]       mem [N_THREADS];

  logic                   mem_we;
  logic [N_THREADS_MSB:0] mem_waddr;
  logic [WIDTH-1:0]       mem_wdata;
  logic                   wr_fire, inv_fire, rd_fire;
  logic [WIDTH-1:0]       rd_data;
  logic                   rd_valid;

  assign ready    = (state_q == ST_RUN);
  assign wr_fire  = ready & ~RST & wr_en;
  assign inv_fire = ready & ~RST & inv_en;
  assign rd_fire  = ready & ~RST & rd_en;

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_thread_num;
    mem_wdata   = din;
    if (!RST) begin
      if (state_q == ST_SWEEP) begin
        if (CLEAR_ON_RESET != 0) begin
          mem_we    = 1'b1;
          mem_waddr = sweep_cnt_q;
          mem_wdata = INIT_VALUE;
          if (sweep_cnt_q == LAST_SLOT) begin
            state_d = ST_RUN;
          end else begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        mem_we = wr_fire;
      end
    end
  end

  // A write to a slot overrides an invalidate of the same slot.
  always_comb begin
    valid_d = valid_q;
    if (inv_fire) valid_d[inv_thread_num] = 1'b0;
    if (wr_fire)  valid_d[wr_thread_num]  = 1'b1;
  end

  // Read sample is taken in the request cycle, with write-first bypass.
  always_comb begin
    rd_data  = mem[rd_thread_num];
    rd_valid = valid_q[rd_thread_num];
    if (wr_fire && (wr_thread_num == rd_thread_num)) begin
      rd_data  = din;
      rd_valid = 1'b1;
    end else if (inv_fire && (inv_thread_num == rd_thread_num)) begin
      rd_valid = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_SWEEP;
      sweep_cnt_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] s1_data_q, s1_data_d, out_data_q, out_data_d;
      logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
      logic             s1_strobe_q, s1_strobe_d, out_strobe_q, out_strobe_d;

      always_comb begin
        s1_data_d    = rd_fire ? rd_data : s1_data_q;
        s1_valid_d   = rd_fire ? rd_valid : s1_valid_q;
        s1_strobe_d  = rd_fire;
        out_data_d   = s1_strobe_q ? s1_data_q : out_data_q;
        out_valid_d  = s1_strobe_q ? s1_valid_q : out_valid_q;
        out_strobe_d = s1_strobe_q;
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_data_q    <= '0;
          s1_valid_q   <= 1'b0;
          s1_strobe_q  <= 1'b0;
          out_data_q   <= '0;
          out_valid_q  <= 1'b0;
          out_strobe_q <= 1'b0;
        end else begin
          s1_data_q    <= s1_data_d;
          s1_valid_q   <= s1_valid_d;
          s1_strobe_q  <= s1_strobe_d;
          out_data_q   <= out_data_d;
          out_valid_q  <= out_valid_d;
          out_strobe_q <= out_strobe_d;
        end
      end

      assign dout        = out_data_q;
      assign dout_valid  = out_valid_q;
      assign dout_strobe = out_strobe_q;
    end else begin : g_lat1
      logic [WIDTH-1:0] out_data_q, out_data_d;
      logic             out_valid_q, out_valid_d;
      logic             out_strobe_q, out_strobe_d;

      always_comb begin
        out_data_d   = rd_fire ? rd_data : out_data_q;
        out_valid_d  = rd_fire ? rd_valid : out_valid_q;
        out_strobe_d = rd_fire;
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          out_data_q   <= '0;
          out_valid_q  <= 1'b0;
          out_strobe_q <= 1'b0;
        end else begin
          out_data_q   <= out_data_d;
          out_valid_q  <= out_valid_d;
          out_strobe_q <= out_strobe_d;
        end
      end

      assign dout        = out_data_q;
      assign dout_valid  = out_valid_q;
      assign dout_strobe = out_strobe_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_thread_state_store.sv
`default_nettype none
// Randomised + directed bench for thread_state_store; two instances (latency 1 and 2)
// share stimulus, a rule-level model feeds one scoreboard queue per instance.
module tb_thread_state_store;
  localparam int N = 16;
  localparam int W = 64;

  typedef struct {
    int          issue;
    logic [63:0] data;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [3:0]   wr_t = '0, inv_t = '0, rd_t = '0;
  logic         wr_en = 1'b0, inv_en = 1'b0, rd_en = 1'b0;
  logic [63:0]  din = '0;

  logic [63:0]  d1_dout, d2_dout;
  logic         d1_valid, d2_valid, d1_strobe, d2_strobe, d1_ready, d2_ready;

  thread_state_store #(.N_THREADS(N), .WIDTH(W), .RD_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_VALUE('0)) u_lat1 (
    .CLK(clk), .RST(rst),
    .wr_thread_num(wr_t), .wr_en(wr_en), .din(din),
    .inv_thread_num(inv_t), .inv_en(inv_en),
    .rd_thread_num(rd_t), .rd_en(rd_en),
    .dout(d1_dout), .dout_valid(d1_valid), .dout_strobe(d1_strobe), .ready(d1_ready)
  );

  thread_state_store #(.N_THREADS(N), .WIDTH(W), .RD_LATENCY(2), .CLEAR_ON_RESET(1), .INIT_VALUE('0)) u_lat2 (
    .CLK(clk), .RST(rst),
    .wr_thread_num(wr_t), .wr_en(wr_en), .din(din),
    .inv_thread_num(inv_t), .inv_en(inv_en),
    .rd_thread_num(rd_t), .rd_en(rd_en),
    .dout(d2_dout), .dout_valid(d2_valid), .dout_strobe(d2_strobe), .ready(d2_ready)
  );

  // Reference model: plain arrays plus a count of reset-free cycles.
  logic [63:0] m_mem [N];
  logic        m_valid [N];
  int          m_cnt = 0;
  int          cyc = 0;
  bit          chk_ready = 1'b0;
  exp_t        q1[$], q2[$];
  exp_t        e1, e2;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      q1.delete();
      q2.delete();
      chk_ready = 1'b1;
    end else if (m_cnt < N) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
    end else begin
      if (rd_en) begin
        e.issue = cyc;
        if (wr_en && wr_t == rd_t) begin
          e.data = din;
          e.v    = 1'b1;
        end else begin
          e.data = m_mem[rd_t];
          e.v    = m_valid[rd_t] && !(inv_en && inv_t == rd_t);
        end
        q1.push_back(e);
        q2.push_back(e);
      end
      if (inv_en) m_valid[inv_t] = 1'b0;
      if (wr_en) begin
        m_mem[wr_t]   = din;
        m_valid[wr_t] = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(bit we, int wt, logic [63:0] d, bit ie, int it, bit re, int rt);
    wr_en  = we;  wr_t  = wt[3:0]; din = d;
    inv_en = ie;  inv_t = it[3:0];
    rd_en  = re;  rd_t  = rt[3:0];
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, 0, 0);
  endtask

  function automatic int pick();
    return ($urandom_range(1) != 0) ? int'($urandom_range(3)) : int'($urandom_range(N - 1));
  endfunction

  task automatic rand_cycles(int n, int pct);
    for (int i = 0; i < n; i++)
      drive($urandom_range(99) < pct, pick(), {$urandom, $urandom},
            $urandom_range(99) < pct / 2, pick(), $urandom_range(99) < pct, pick());
  endtask

  always @(negedge clk) begin
    if (chk_ready) begin
      check("ready_lat1", 64'(d1_ready), 64'(m_cnt >= N));
      check("ready_lat2", 64'(d2_ready), 64'(m_cnt >= N));
    end
  end

  always @(negedge clk) begin
    if (d1_strobe === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL lat1_strobe @cyc %0d: got strobe, required none", cyc);
      end else begin
        e1 = q1.pop_front();
        check("lat1_dout", d1_dout, e1.data);
        check("lat1_dout_valid", 64'(d1_valid), 64'(e1.v));
        check("lat1_latency", 64'(cyc - e1.issue), 64'd1);
      end
    end else if (q1.size() > 0 && q1[0].issue + 1 <= cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL lat1_strobe @cyc %0d: got no strobe, required one", cyc);
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (d2_strobe === 1'b1) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL lat2_strobe @cyc %0d: got strobe, required none", cyc);
      end else begin
        e2 = q2.pop_front();
        check("lat2_dout", d2_dout, e2.data);
        check("lat2_dout_valid", 64'(d2_valid), 64'(e2.v));
        check("lat2_latency", 64'(cyc - e2.issue), 64'd2);
      end
    end else if (q2.size() > 0 && q2[0].issue + 2 <= cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL lat2_strobe @cyc %0d: got no strobe, required one", cyc);
      void'(q2.pop_front());
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (wr_en)  assert (int'(wr_t) < N);
      if (inv_en) assert (int'(inv_t) < N);
      if (rd_en)  assert (int'(rd_t) < N);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_mem[i]   = '0;
      m_valid[i] = 1'b0;
    end
    // Reset values and initial sweep
    rst = 1'b1;
    idle(3);
    check("rst_dout_lat1", d1_dout, '0);
    check("rst_dout_lat2", d2_dout, '0);
    check("rst_valid_lat1", 64'(d1_valid), '0);
    check("rst_strobe_lat2", 64'(d2_strobe), '0);
    rst = 1'b0;
    idle(N);
    drive(0, 0, '0, 0, 0, 1, 5);
    idle(3);

    // Write then read
    drive(1, 3, 64'hDEADBEEF_01234567, 0, 0, 0, 0);
    drive(0, 0, '0, 0, 0, 1, 3);
    idle(3);

    // Bypass and snapshot
    drive(1, 7, 64'hA5, 0, 0, 1, 7);
    drive(1, 7, 64'hB6, 0, 0, 0, 0);
    idle(3);

    // Invalidate, then write+invalidate on the same slot
    drive(1, 2, 64'h11, 0, 0, 0, 0);
    drive(0, 0, '0, 1, 2, 0, 0);
    drive(0, 0, '0, 0, 0, 1, 2);
    drive(1, 2, 64'h22, 1, 2, 0, 0);
    drive(0, 0, '0, 0, 0, 1, 2);
    drive(1, 9, 64'h99, 1, 9, 1, 9);
    drive(0, 0, '0, 1, 4, 1, 4);
    idle(3);

    // Reset pulsed mid-sweep with traffic that must be ignored
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rand_cycles(9, 80);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rand_cycles(N, 80);
    for (int k = 0; k < N; k++) drive(0, 0, '0, 0, 0, 1, k);
    idle(3);

    // Streaming back-to-back reads
    for (int k = 0; k < N; k++) drive(1, k, 64'h100 + 64'(k), 0, 0, 0, 0);
    for (int k = 0; k < N; k++) drive(0, 0, '0, 0, 0, 1, k);
    idle(3);

    // Reset in RUN with reads in flight
    drive(0, 0, '0, 0, 0, 1, 1);
    drive(0, 0, '0, 0, 0, 1, 4);
    rst = 1'b1;
    drive(1, 6, 64'h66, 0, 0, 1, 5);
    rst = 1'b0;
    idle(N + 2);

    // Random traffic
    rand_cycles(400, 50);
    idle(6);
    check("lat1_queue_drained", 64'(q1.size()), '0);
    check("lat2_queue_drained", 64'(q2.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/thread_state_store.md
Name: thread_state_store

Overview:
- Per-thread context store between blocks in the sha512 engine, generalised from the single-width saved-state RAM.
- Holds one WIDTH-bit record per thread in distributed RAM.
- Adds a per-thread valid bit, explicit invalidate, write-first bypass, selectable read latency, a read strobe, and an optional post-reset clearing sweep.
- Sits between the process-bytes unit and its thread scheduler; the scheduler saves state on block end and restores it on block start.

Parameters:
- N_THREADS, 16, number of thread slots; any value ≥2, not necessarily a power of 2.
- N_THREADS_MSB, MSB(N_THREADS-1), MSB of thread number buses.
- WIDTH, 64, record width in bits.
- RD_LATENCY, 1, cycles from rd_en to dout/dout_strobe; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = after reset, sweep every entry to INIT_VALUE; 0 = no sweep.
- INIT_VALUE, 0, WIDTH-bit value written by the sweep.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- wr_thread_num  in  N_THREADS_MSB+1  thread slot to write.
- wr_en  in  1  write din to slot; sets slot valid.
- din  in  WIDTH  write data.
- inv_thread_num  in  N_THREADS_MSB+1  thread slot to invalidate.
- inv_en  in  1  clear valid bit of slot; RAM content unchanged.
- rd_thread_num  in  N_THREADS_MSB+1  thread slot to read.
- rd_en  in  1  read request.
- dout  out  WIDTH  read data, registered.
- dout_valid  out  1  valid bit of the slot read, aligned with dout.
- dout_strobe  out  1  one-cycle pulse marking new dout.
- ready  out  1  store accepts requests.

Behaviour:
- Reset values while RST=1: dout=0, dout_valid=0, dout_strobe=0, ready=0, all valid bits 0, sweep counter 0. RAM contents are not reset directly.
- Sweep, CLEAR_ON_RESET=1:
  - FSM states: SWEEP → RUN.
  - SWEEP begins on the first cycle with RST=0. It writes INIT_VALUE to slot k on the k-th cycle, k=0..N_THREADS-1.
  - Enter RUN, with ready=1, on the cycle after slot N_THREADS-1 is written. ready is therefore first seen high N_THREADS cycles after RST falls.
- CLEAR_ON_RESET=0: the FSM enters RUN on the first cycle with RST=0, so ready=1 one cycle after RST falls.
- RST asserted mid-sweep or mid-RUN: everything returns to reset values; the sweep restarts from slot 0. Any read in flight is dropped and no strobe is emitted.
- While ready=0: wr_en, inv_en and rd_en are ignored (no RAM write, no valid change, no strobe).
- Write: in RUN with wr_en=1, mem[wr_thread_num] and valid[wr_thread_num] update at the clock edge.
- Invalidate: inv_en=1 clears valid[inv_thread_num] at the clock edge.
- wr_en and inv_en on the same slot in the same cycle: the write wins and valid=1. On different slots, both take effect.
- Read, RD_LATENCY=1: rd_en in cycle t → dout, dout_valid and dout_strobe=1 in cycle t+1.
- Read, RD_LATENCY=2: same outputs in cycle t+2; the extra stage is a plain output register.
- Without rd_en, dout and dout_valid hold their last values and dout_strobe=0.
- Write-first bypass:
  - If rd_en and wr_en target the same slot in cycle t, the read returns din of cycle t with dout_valid=1.
  - If rd_en and inv_en target the same slot without a write, dout_valid=0 and dout returns the stored data.
- Snapshot rule: read data is sampled in the rd_en cycle. Writes in later cycles do not alter a read already in flight (matters for RD_LATENCY=2).
- Back-to-back reads are accepted every cycle. The strobes form a matching contiguous train.
- Thread numbers ≥ N_THREADS: behaviour undefined; not driven by the scheduler. The bench checks this with an assertion.

Test Plan:
1. Reset, N_THREADS=16, CLEAR_ON_RESET=1: RST high 3 cycles, then low → ready=0 for 16 cycles, then 1. Read slot 5 → dout=0, dout_valid=0, strobe one cycle later.
2. Write 64'hDEADBEEF_01234567 to slot 3, read slot 3 next cycle → dout=64'hDEADBEEF_01234567, dout_valid=1 at t+1 (RD_LATENCY=1), and at t+2 with RD_LATENCY=2.
3. Bypass: same cycle wr_en slot 7 din=64'hA5, rd_en slot 7 → dout=64'hA5, dout_valid=1. With RD_LATENCY=2, a write of 64'hB6 to slot 7 at t+1 leaves dout=64'hA5.
4. Invalidate: slot 2 holds 64'h11. inv_en slot 2, then read → dout=64'h11, dout_valid=0. Same-cycle wr 64'h22 + inv on slot 2, then read → 64'h22, valid=1.
5. Reset mid-sweep: RST pulsed at sweep slot 9 → ready stays 0 for 16 more cycles after RST falls. wr_en/rd_en during the sweep produce no strobe and no write.
6. Streaming: 16 consecutive reads of slots 0..15, each previously written with value 64'h100+k → 16 contiguous strobes, dout=64'h100+k in order.
